// File: rtl/dpram_core.sv
// dpram_core: synchronous dual-port RAM with one-cycle registered reads,
// write-first collision bypass, and per-entry "written since reset" tracking
// exposed as a read error flag and a fill counter.
module dpram_core #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  all_written
);

  localparam int                DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  // Storage is never reset: an entry is only observable once its valid bit is set.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [ADDR_WIDTH:0]   r_fill_count;
  logic                  r_all_written;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_rd_err;

  logic                  w_new_entry;
  logic [ADDR_WIDTH:0]   w_fill_next;
  logic                  w_collide;

  // A write to a not-yet-valid entry grows the distinct-entry count by one.
  always_comb begin
    w_new_entry = wr_en && !r_valid[wr_addr];
    w_fill_next = r_fill_count + {{ADDR_WIDTH{1'b0}}, w_new_entry};
    w_collide   = wr_en && (wr_addr == rd_addr);
  end

  // Write port into the data array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Valid-bit vector, fill counter and sticky full flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid       <= '0;
      r_fill_count  <= '0;
      r_all_written <= 1'b0;
    end else begin
      if (wr_en) begin
        r_valid[wr_addr] <= 1'b1;
      end
      r_fill_count  <= w_fill_next;
      r_all_written <= (w_fill_next == FULL_CNT);
    end
  end

  // Registered read port: bypass on collision, error on never-written entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else if (rd_en) begin
      r_rd_valid <= 1'b1;
      if (w_collide) begin
        r_rd_data <= wr_data;
        r_rd_err  <= 1'b0;
      end else if (r_valid[rd_addr]) begin
        r_rd_data <= r_mem[rd_addr];
        r_rd_err  <= 1'b0;
      end else begin
        r_rd_data <= '0;
        r_rd_err  <= 1'b1;
      end
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign rd_err      = r_rd_err;
  assign fill_count  = r_fill_count;
  assign all_written = r_all_written;

endmodule
